// File: rtl/life_row_stepper.sv
// life_row_stepper: streaming Life next-generation engine.
// Accepts a frame as HEIGHT rows of WIDTH cells and emits the next generation
// row by row, with all WIDTH cells of a row computed in parallel.
// Optional feature: define LIFE_TORUS_EN for wrap-around edges. It adds the
// row0/row1 copies and the TAIL0 state, and changes the output order to 1..HEIGHT-1, 0.

module life_row_stepper #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [8:0]                i_birth_mask,
    input  logic [8:0]                i_survive_mask,
    input  logic                      i_row_valid,
    input  logic [WIDTH-1:0]          i_row_data,
    output logic                      o_row_ready,
    output logic                      o_row_valid,
    output logic [WIDTH-1:0]          o_row_data,
    output logic [$clog2(HEIGHT)-1:0] o_row_idx,
    output logic                      o_row_last,
    input  logic                      i_out_ready
);

    localparam int RW = $clog2(HEIGHT);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    localparam logic [2:0] S_FILL0 = 3'd0;
    localparam logic [2:0] S_FILL1 = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_TAIL1 = 3'd3;
`ifdef LIFE_TORUS_EN
    localparam logic [2:0] S_TAIL0 = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;
    logic [8:0]       birth_q, survive_q;
    logic [WIDTH-1:0] prev_q, cur_q;
`ifdef LIFE_TORUS_EN
    logic [WIDTH-1:0] row0_q, row1_q;
`endif
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [RW-1:0]    out_idx_q;
    logic             out_last_q;

    logic             slot_free, in_tail, accept, emit, emit_last;
    logic [WIDTH-1:0] emit_above, emit_center, emit_below, emit_data;
    logic [RW-1:0]    emit_idx;

    // Next state of one row from its 3-row window; off-grid cells are dead or wrapped.
    function automatic logic [WIDTH-1:0] next_row(
        input logic [WIDTH-1:0] above,
        input logic [WIDTH-1:0] center,
        input logic [WIDTH-1:0] below,
        input logic [8:0]       birth,
        input logic [8:0]       survive
    );
        logic [WIDTH+1:0] pa, pc, pb;
        logic [3:0]       cnt;
        logic [WIDTH-1:0] res;
        // Padded index 0 is column -1, index WIDTH+1 is column WIDTH.
`ifdef LIFE_TORUS_EN
        pa = {above[0],  above,  above[WIDTH-1]};
        pc = {center[0], center, center[WIDTH-1]};
        pb = {below[0],  below,  below[WIDTH-1]};
`else
        pa = {1'b0, above,  1'b0};
        pc = {1'b0, center, 1'b0};
        pb = {1'b0, below,  1'b0};
`endif
        res = '0;
        for (int c = 0; c < WIDTH; c++) begin
            cnt = {3'b000, pa[c]} + {3'b000, pa[c+1]} + {3'b000, pa[c+2]}
                + {3'b000, pc[c]}                     + {3'b000, pc[c+2]}
                + {3'b000, pb[c]} + {3'b000, pb[c+1]} + {3'b000, pb[c+2]};
            res[c] = center[c] ? survive[cnt] : birth[cnt];
        end
        return res;
    endfunction

`ifdef LIFE_TORUS_EN
    assign in_tail = (state_q == S_TAIL1) || (state_q == S_TAIL0);
`else
    assign in_tail = (state_q == S_TAIL1);
`endif
    assign slot_free   = !out_valid_q || i_out_ready;
    assign o_row_ready = !i_rst && !in_tail && slot_free;
    assign accept      = i_row_valid && o_row_ready;
    assign emit_data   = next_row(emit_above, emit_center, emit_below, birth_q, survive_q);

    // FSM sequencing, row counting and selection of the window for the row being emitted.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        emit        = 1'b0;
        emit_above  = prev_q;
        emit_center = cur_q;
        emit_below  = i_row_data;
        emit_idx    = '0;
        emit_last   = 1'b0;
        case (state_q)
            S_FILL0: begin
                if (accept) begin
                    state_d   = S_FILL1;
                    row_cnt_d = RW'(1);
                end
            end
            S_FILL1: begin
                if (accept) begin
                    state_d   = S_RUN;
                    row_cnt_d = row_cnt_q + RW'(1);
`ifndef LIFE_TORUS_EN
                    // Row 0 sees an all-dead row above it.
                    emit       = 1'b1;
                    emit_above = '0;
                    emit_idx   = '0;
`endif
                end
            end
            S_RUN: begin
                if (accept) begin
                    emit     = 1'b1;
                    emit_idx = row_cnt_q - RW'(1);
                    if (row_cnt_q == LAST_ROW) state_d = S_TAIL1;
                    else row_cnt_d = row_cnt_q + RW'(1);
                end
            end
            S_TAIL1: begin
                if (slot_free) begin
                    emit     = 1'b1;
                    emit_idx = LAST_ROW;
`ifdef LIFE_TORUS_EN
                    emit_below = row0_q;
                    state_d    = S_TAIL0;
`else
                    emit_below = '0;
                    emit_last  = 1'b1;
                    state_d    = S_FILL0;
`endif
                end
            end
`ifdef LIFE_TORUS_EN
            S_TAIL0: begin
                if (slot_free) begin
                    // Row 0 wraps: last row above, stored row 1 below.
                    emit        = 1'b1;
                    emit_above  = cur_q;
                    emit_center = row0_q;
                    emit_below  = row1_q;
                    emit_idx    = '0;
                    emit_last   = 1'b1;
                    state_d     = S_FILL0;
                end
            end
`endif
            default: state_d = S_FILL0;
        endcase
    end

    // Control state, per-frame rule latch and the single output slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_FILL0;
            row_cnt_q   <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            if (accept && state_q == S_FILL0) begin
                birth_q   <= i_birth_mask;
                survive_q <= i_survive_mask;
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= emit_data;
                out_idx_q   <= emit_idx;
                out_last_q  <= emit_last;
            end else if (i_out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffers: shift the row window on every accepted input row.
    // NOTE: no reset here; each buffer is written by the current frame before it is read.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            prev_q <= cur_q;
            cur_q  <= i_row_data;
`ifdef LIFE_TORUS_EN
            if (state_q == S_FILL0) row0_q <= i_row_data;
            if (state_q == S_FILL1) row1_q <= i_row_data;
`endif
        end
    end

    assign o_row_valid = out_valid_q;
    assign o_row_data  = out_data_q;
    assign o_row_idx   = out_idx_q;
    assign o_row_last  = out_last_q;

endmodule

// File: tb/tb_life_row_stepper.sv
// tb_life_row_stepper: directed bench for life_row_stepper (WIDTH=8, HEIGHT=8).
// Expected rows come from a reference Life model and are queued when a frame is driven.
// Honours LIFE_TORUS_EN the same way the design does.

module tb_life_row_stepper;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int RW = 3;

    localparam logic [8:0] STD_B = 9'b0_0000_1000;
    localparam logic [8:0] STD_S = 9'b0_0000_1100;
    localparam logic [8:0] HL_B  = 9'b0_0100_1000;

`ifdef LIFE_TORUS_EN
    localparam int TAIL_BUBBLES = 2;
`else
    localparam int TAIL_BUBBLES = 1;
`endif

    typedef struct packed {
        logic [W-1:0]  data;
        logic [RW-1:0] idx;
        logic          last;
    } beat_t;

    logic          i_clk;
    logic          i_rst;
    logic [8:0]    i_birth_mask;
    logic [8:0]    i_survive_mask;
    logic          i_row_valid;
    logic [W-1:0]  i_row_data;
    logic          o_row_ready;
    logic          o_row_valid;
    logic [W-1:0]  o_row_data;
    logic [RW-1:0] o_row_idx;
    logic          o_row_last;
    logic          i_out_ready;

    beat_t        exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] frame [H];
    logic         bp_en = 1'b0;
    logic         held  = 1'b0;
    beat_t        held_b;
    int           st0, strest;

    life_row_stepper #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_birth_mask   (i_birth_mask),
        .i_survive_mask (i_survive_mask),
        .i_row_valid    (i_row_valid),
        .i_row_data     (i_row_data),
        .o_row_ready    (o_row_ready),
        .o_row_valid    (o_row_valid),
        .o_row_data     (o_row_data),
        .o_row_idx      (o_row_idx),
        .o_row_last     (o_row_last),
        .i_out_ready    (i_out_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Downstream ready: steady 1, or toggling 1010... while bp_en is set.
    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (bp_en) i_out_ready = ~i_out_ready;
            else i_out_ready = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: next generation of 'frame', queued in the mode's output order.
    task automatic push_frame(input logic [8:0] b, input logic [8:0] s);
        logic [W-1:0] nxt [H];
        beat_t        bt;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0)) begin
`ifdef LIFE_TORUS_EN
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            n += int'(frame[rr][cc]);
`else
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += int'(frame[rr][cc]);
`endif
                        end
                    end
                end
                nxt[r][c] = frame[r][c] ? s[n] : b[n];
            end
        end
        for (int k = 0; k < H; k++) begin
            int r;
`ifdef LIFE_TORUS_EN
            r = (k + 1) % H;
`else
            r = k;
`endif
            bt.data = nxt[r];
            bt.idx  = RW'(r);
            bt.last = (k == H - 1);
            exp_q.push_back(bt);
        end
    endtask

    // Drive one row and hold it until accepted; reports cycles spent waiting.
    task automatic send_row(input logic [W-1:0] d, input logic [8:0] b, input logic [8:0] s,
                            output int stalls);
        logic done;
        done           = 1'b0;
        stalls         = 0;
        i_row_valid    = 1'b1;
        i_row_data     = d;
        i_birth_mask   = b;
        i_survive_mask = s;
        while (!done) begin
            @(negedge i_clk);
            if (o_row_ready) done = 1'b1;
            else stalls++;
            @(posedge i_clk);
            #1;
            if (!done && stalls > 50) begin
                check("accept_timeout", 32'(stalls), 32'd0);
                done = 1'b1;
            end
        end
        i_row_valid = 1'b0;
    endtask

    // Send 'frame'; masks switch from (b0,s0) to (b1,s1) at row sw. Expected uses the row-0 masks.
    task automatic send_frame(input logic [8:0] b0, input logic [8:0] s0,
                              input logic [8:0] b1, input logic [8:0] s1, input int sw,
                              output int stall0, output int stall_rest);
        int st;
        push_frame(b0, s0);
        stall_rest = 0;
        stall0     = 0;
        for (int k = 0; k < H; k++) begin
            send_row(frame[k], (k < sw) ? b0 : b1, (k < sw) ? s0 : s1, st);
            if (k == 0) stall0 = st;
            else stall_rest += st;
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge i_clk);
            #1;
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_frame();
        for (int r = 0; r < H; r++) frame[r] = '0;
    endtask

    // Output monitor: scoreboard pop on every taken beat, stall stability, ready rule.
    always @(negedge i_clk) begin
        if (i_rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 32'(o_row_valid), 32'd1);
                check("stall_data",  32'(o_row_data),  32'(held_b.data));
                check("stall_idx",   32'(o_row_idx),   32'(held_b.idx));
                check("stall_last",  32'(o_row_last),  32'(held_b.last));
            end
            if (o_row_valid && !i_out_ready) check("ready_when_full", 32'(o_row_ready), 32'd0);
            if (o_row_valid && i_out_ready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("row_data", 32'(o_row_data), 32'(e.data));
                    check("row_idx",  32'(o_row_idx),  32'(e.idx));
                    check("row_last", 32'(o_row_last), 32'(e.last));
                end
            end
            held   = o_row_valid && !i_out_ready;
            held_b = {o_row_data, o_row_idx, o_row_last};
        end
    end

    initial begin
        i_rst          = 1'b1;
        i_row_valid    = 1'b0;
        i_row_data     = '0;
        i_birth_mask   = STD_B;
        i_survive_mask = STD_S;
        clear_frame();

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("rst_ready", 32'(o_row_ready), 32'd0);
        check("rst_valid", 32'(o_row_valid), 32'd0);
        check("rst_data",  32'(o_row_data),  32'd0);
        check("rst_idx",   32'(o_row_idx),   32'd0);
        check("rst_last",  32'(o_row_last),  32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_rst", 32'(o_row_ready), 32'd1);
        @(posedge i_clk);
        #1;

        // Blinker, full throughput
        clear_frame();
        frame[3] = 8'b0001_1100;
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        check("blinker_row0_stall", 32'(st0), 32'd0);
        check("blinker_throughput", 32'(strest), 32'd0);
        drain("blinker_drain");

        // Block still life, second frame back to back
        clear_frame();
        frame[2] = 8'b0001_1000;
        frame[3] = 8'b0001_1000;
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        check("b2b_tail_bubbles", 32'(st0), 32'(TAIL_BUBBLES));
        check("b2b_throughput", 32'(strest), 32'd0);
        drain("block_drain");

        // Edge blinker
        clear_frame();
        frame[3] = 8'b0000_0001;
        frame[4] = 8'b0000_0001;
        frame[5] = 8'b0000_0001;
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        drain("edge_drain");

        // Rule latch: HighLife at row 0, standard from row 4 on; HighLife holds all frame
        clear_frame();
        frame[1] = 8'b0000_0111;
        frame[3] = 8'b0000_0111;
        frame[5] = 8'b0000_0111;
        frame[7] = 8'b0000_0111;
        send_frame(HL_B, STD_S, STD_B, STD_S, 4, st0, strest);
        drain("latch_drain");

        // Backpressure with a glider
        clear_frame();
        frame[1] = 8'b0000_0010;
        frame[2] = 8'b0000_0100;
        frame[3] = 8'b0000_0111;
        bp_en = 1'b1;
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        drain("bp_drain");
        bp_en = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset mid-frame after 4 rows of an empty frame
        clear_frame();
        begin
            beat_t bt;
            bt.data = '0;
            bt.last = 1'b0;
`ifndef LIFE_TORUS_EN
            bt.idx = 3'd0;
            exp_q.push_back(bt);
`endif
            bt.idx = 3'd1;
            exp_q.push_back(bt);
            bt.idx = 3'd2;
            exp_q.push_back(bt);
        end
        for (int k = 0; k < 4; k++) send_row(frame[k], STD_B, STD_S, st0);
        drain("partial_drain");
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_ready", 32'(o_row_ready), 32'd0);
        check("midrst_valid", 32'(o_row_valid), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        frame[3] = 8'b0001_1100;
        send_frame(STD_B, STD_S, STD_B, STD_S, H, st0, strest);
        check("postrst_row0_stall", 32'(st0), 32'd0);
        drain("postrst_drain");
        repeat (3) @(posedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
